// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the serial memory loaders: FSM states,
// protocol bytes and the order of the session header fields.
package uart_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        P_CKSUM,
        P_ADDR,
        P_COUNT,
        P_DATA,
        P_RESP,
        DONE
    } loader_state_e;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'h84;
    localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
    localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

    // Session header as it appears on the wire, first byte first.
    typedef enum logic [1:0] {
        HDR_SYNC,
        HDR_COUNT_LO,
        HDR_COUNT_HI
    } header_field_e;

    localparam int HEADER_BYTES = 3;

    // States in which the host owes us a byte, so silence means a dead link.
    function automatic logic timed_state(input loader_state_e s);
        return (s != IDLE) && (s != P_RESP) && (s != DONE);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Loadable down-counter: clear reloads it, it counts down while enabled and
// flags expiry once it has run down to zero.
module loader_timeout #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    // Kept independent of clear so the owner can derive clear from its next state.
    assign expired = enable && (count == '0);

endmodule

// File: rtl/uart_packet_loader.sv
// Byte-stream loader: parses a sync/count session header and a run of
// checksummed packets into memory writes, answering each packet with ACK/NAK.
module uart_packet_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_BYTES     = 2,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
    parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    output logic                    wr_en,
    output logic [8*ADDR_BYTES-1:0] wr_addr,
    output logic [7:0]              wr_data,
    output logic                    loader_busy,
    output logic [15:0]             packets_left,
    output logic                    done_tick,
    output logic                    error_tick,
    output logic                    timeout_tick
);

    localparam int AW  = 8 * ADDR_BYTES;
    localparam int AIW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_e  state, state_n;
    logic [15:0]    packets_left_n;
    logic [7:0]     sum, sum_n;
    logic [AW-1:0]  cur_addr, cur_addr_n;
    logic [AIW-1:0] addr_idx, addr_idx_n;
    logic [7:0]     data_left, data_left_n;

    logic           tx_start_n;
    logic [7:0]     tx_data_n;
    logic           wr_en_n;
    logic [AW-1:0]  wr_addr_n;
    logic [7:0]     wr_data_n;
    logic           loader_busy_n;
    logic           done_tick_n;
    logic           error_tick_n;
    logic           timeout_tick_n;

    logic           timer_enable;
    logic           timer_clear;
    logic           timer_expired;

    assign timer_enable = timed_state(state);
    assign timer_clear  = rx_valid || (state_n != state);

    loader_timeout #(
        .WIDTH(TW)
    ) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (timer_enable),
        .clear     (timer_clear),
        .load_value(TW'(TIMEOUT_CYCLES - 1)),
        .expired   (timer_expired)
    );

    always_comb begin
        state_n        = state;
        packets_left_n = packets_left;
        sum_n          = sum;
        cur_addr_n     = cur_addr;
        addr_idx_n     = addr_idx;
        data_left_n    = data_left;
        tx_start_n     = 1'b0;
        tx_data_n      = tx_data;
        wr_en_n        = 1'b0;
        wr_addr_n      = wr_addr;
        wr_data_n      = wr_data;
        error_tick_n   = 1'b0;
        timeout_tick_n = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) state_n = CNT_LO;
            end
            CNT_LO: begin
                if (rx_valid) begin
                    packets_left_n = {packets_left[15:8], rx_data};
                    state_n        = CNT_HI;
                end
            end
            CNT_HI: begin
                if (rx_valid) begin
                    packets_left_n = {rx_data, packets_left[7:0]};
                    state_n = ({rx_data, packets_left[7:0]} == 16'd0) ? DONE : P_CKSUM;
                end
            end
            P_CKSUM: begin
                if (rx_valid) begin
                    sum_n      = rx_data;
                    addr_idx_n = '0;
                    state_n    = P_ADDR;
                end
            end
            P_ADDR: begin
                if (rx_valid) begin
                    sum_n      = sum + rx_data;
                    cur_addr_n = (cur_addr << 8) | AW'(rx_data);
                    if (addr_idx == AIW'(ADDR_BYTES - 1)) state_n = P_COUNT;
                    else addr_idx_n = addr_idx + AIW'(1);
                end
            end
            P_COUNT: begin
                if (rx_valid) begin
                    sum_n       = sum + rx_data;
                    data_left_n = rx_data;
                    state_n     = P_DATA;
                end
            end
            P_DATA: begin
                if (rx_valid) begin
                    sum_n      = sum + rx_data;
                    wr_en_n    = 1'b1;
                    wr_addr_n  = cur_addr;
                    wr_data_n  = rx_data;
                    cur_addr_n = cur_addr + AW'(1);
                    if (data_left == 8'd0) state_n = P_RESP;
                    else data_left_n = data_left - 8'd1;
                end
            end
            P_RESP: begin
                // Bytes arriving here are dropped: the host waits for our answer.
                if (!tx_busy) begin
                    tx_start_n = 1'b1;
                    if (sum == 8'd0) begin
                        tx_data_n      = ACK_BYTE;
                        packets_left_n = packets_left - 16'd1;
                        state_n        = (packets_left == 16'd1) ? DONE : P_CKSUM;
                    end else begin
                        tx_data_n    = NAK_BYTE;
                        error_tick_n = 1'b1;
                        state_n      = P_CKSUM;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (timer_enable && !rx_valid && timer_expired) begin
            state_n        = IDLE;
            packets_left_n = 16'd0;
            timeout_tick_n = 1'b1;
        end

        loader_busy_n = (state_n != IDLE);
        done_tick_n   = (state_n == DONE) && (state != DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            packets_left <= 16'd0;
            sum          <= 8'd0;
            cur_addr     <= '0;
            addr_idx     <= '0;
            data_left    <= 8'd0;
            tx_start     <= 1'b0;
            tx_data      <= 8'd0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= 8'd0;
            loader_busy  <= 1'b0;
            done_tick    <= 1'b0;
            error_tick   <= 1'b0;
            timeout_tick <= 1'b0;
        end else begin
            state        <= state_n;
            packets_left <= packets_left_n;
            sum          <= sum_n;
            cur_addr     <= cur_addr_n;
            addr_idx     <= addr_idx_n;
            data_left    <= data_left_n;
            tx_start     <= tx_start_n;
            tx_data      <= tx_data_n;
            wr_en        <= wr_en_n;
            wr_addr      <= wr_addr_n;
            wr_data      <= wr_data_n;
            loader_busy  <= loader_busy_n;
            done_tick    <= done_tick_n;
            error_tick   <= error_tick_n;
            timeout_tick <= timeout_tick_n;
        end
    end

endmodule

// File: tb/tb_uart_packet_loader.sv
// Bench for uart_packet_loader: directed sessions plus randomized packets
// checked against a byte-level model of the loader protocol.
module tb_uart_packet_loader;

    localparam int         AW             = 16;
    localparam int         TIMEOUT_CYCLES = 50;
    localparam logic [7:0] SYNC           = 8'h84;
    localparam logic [7:0] ACK            = 8'h06;
    localparam logic [7:0] NAK            = 8'h15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          loader_busy;
    logic [15:0]   packets_left;
    logic          done_tick;
    logic          error_tick;
    logic          timeout_tick;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int tx_count = 0;
    int done_count = 0;

    logic [AW+7:0] exp_q[$];
    logic [AW+7:0] exp_word;

    always #5 clk = ~clk;

    uart_packet_loader #(
        .ADDR_BYTES    (2),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .loader_busy (loader_busy),
        .packets_left(packets_left),
        .done_tick   (done_tick),
        .error_tick  (error_tick),
        .timeout_tick(timeout_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (wr_en) begin
                wr_count++;
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(exp_word[AW+7:8]));
                    check("wr_data", 32'(wr_data), 32'(exp_word[7:0]));
                end
            end
            if (tx_start) tx_count++;
            if (done_tick) done_count++;
        end
    end

    // Gap goes before the byte so the caller regains control one cycle after it.
    task automatic send_byte(input logic [7:0] b, input bit is_data);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        if (is_data) check("wr_latency", 32'(wr_en), 32'd1);
    endtask

    task automatic send_header(input logic [15:0] count);
        send_byte(SYNC, 1'b0);
        send_byte(count[7:0], 1'b0);
        send_byte(count[15:8], 1'b0);
        check("packets_left_loaded", 32'(packets_left), 32'(count));
    endtask

    task automatic wait_response(input logic [7:0] exp_byte, input int exp_left, input bit exp_err);
        int k;
        k = 1;
        @(negedge clk);
        while (!tx_start && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("tx_start_seen", 32'(tx_start), 32'd1);
        check("tx_data", 32'(tx_data), 32'(exp_byte));
        check("packets_left_after_resp", 32'(packets_left), 32'(exp_left));
        check("error_tick", 32'(error_tick), 32'(exp_err));
    endtask

    task automatic check_done(input int d0);
        repeat (3) @(negedge clk);
        check("done_tick_count", 32'(done_count - d0), 32'd1);
        check("busy_after_done", 32'(loader_busy), 32'd0);
    endtask

    // The example packet: base 0x1234, two bytes AA 55, checksum given by caller.
    task automatic directed_packet(input logic [7:0] cks, input int exp_left, input bit exp_err);
        exp_q.push_back({16'h1234, 8'hAA});
        exp_q.push_back({16'h1235, 8'h55});
        send_byte(cks, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        wait_response(exp_err ? NAK : ACK, exp_left, exp_err);
    endtask

    // Model: checksum byte makes the byte sum of the packet 0 mod 256 unless corrupted.
    task automatic run_packet(input logic [15:0] base, input int n, input bit corrupt,
                              input int busy_hold, input bit force_sync, inout int exp_left);
        logic [7:0] data[$];
        logic [7:0] d;
        logic [7:0] cks;
        int sum;
        int seen;
        bit ack;
        sum = int'(base[15:8]) + int'(base[7:0]) + n;
        for (int i = 0; i <= n; i++) begin
            d = (force_sync && (i % 2 == 0)) ? SYNC : 8'($urandom_range(0, 255));
            data.push_back(d);
            sum += int'(d);
        end
        cks = 8'((256 - (sum % 256)) % 256);
        if (corrupt) cks = cks + 8'd1;
        ack = ((int'(cks) + sum) % 256) == 0;
        send_byte(cks, 1'b0);
        send_byte(base[15:8], 1'b0);
        send_byte(base[7:0], 1'b0);
        send_byte(8'(n), 1'b0);
        for (int i = 0; i <= n; i++) begin
            exp_q.push_back({16'((int'(base) + i) % 65536), data[i]});
            if (i == n && busy_hold > 0) tx_busy = 1'b1;
            send_byte(data[i], 1'b1);
        end
        if (busy_hold > 0) begin
            seen = 0;
            repeat (busy_hold) begin
                @(negedge clk);
                if (tx_start) seen++;
            end
            check("tx_held_while_busy", 32'(seen), 32'd0);
            tx_busy = 1'b0;
        end
        if (ack) exp_left--;
        wait_response(ack ? ACK : NAK, exp_left, !ack);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int w0;
        int t0;
        int k;
        int left;
        logic [7:0] stray[4];

        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_busy  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_start", 32'(tx_start), 32'd0);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_busy", 32'(loader_busy), 32'd0);
        check("reset_packets_left", 32'(packets_left), 32'd0);
        check("reset_ticks", 32'({done_tick, error_tick, timeout_tick}), 32'd0);
        check("reset_data_outs", 32'({tx_data, wr_addr, wr_data}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Example session, good checksum.
        d0 = done_count;
        send_header(16'd1);
        check("busy_in_session", 32'(loader_busy), 32'd1);
        directed_packet(8'hBA, 0, 1'b0);
        check_done(d0);

        // Bad checksum, then resend.
        d0 = done_count;
        send_header(16'd1);
        directed_packet(8'hBB, 1, 1'b1);
        directed_packet(8'hBA, 0, 1'b0);
        check_done(d0);

        // Empty session.
        d0 = done_count;
        w0 = wr_count;
        t0 = tx_count;
        send_header(16'd0);
        check_done(d0);
        check("empty_no_writes", 32'(wr_count - w0), 32'd0);
        check("empty_no_tx", 32'(tx_count - t0), 32'd0);

        // Address wrap and a maximum-length packet.
        d0 = done_count;
        w0 = wr_count;
        left = 2;
        send_header(16'd2);
        run_packet(16'hFFFF, 1, 1'b0, 0, 1'b0, left);
        run_packet(16'($urandom), 255, 1'b0, 0, 1'b0, left);
        check_done(d0);
        check("wrap_and_max_writes", 32'(wr_count - w0), 32'd258);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Random packets, some corrupted; the first one waits behind a busy transmitter.
        d0 = done_count;
        left = 4;
        send_header(16'd4);
        k = 0;
        while (left > 0 && k < 20) begin
            run_packet(16'($urandom), $urandom_range(0, 40), ($urandom_range(0, 2) == 0),
                       (k == 0) ? 20 : 0, 1'b0, left);
            k++;
        end
        check_done(d0);

        // Host stalls after the address bytes.
        t0 = tx_count;
        send_header(16'd1);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h00, 1'b0);
        k = 1;
        @(negedge clk);
        while (!timeout_tick && k < 3 * TIMEOUT_CYCLES) begin
            @(negedge clk);
            k++;
        end
        check("timeout_tick", 32'(timeout_tick), 32'd1);
        check("timeout_latency_ok", 32'(k >= TIMEOUT_CYCLES - 1 && k <= TIMEOUT_CYCLES + 1), 32'd1);
        check("timeout_busy_low", 32'(loader_busy), 32'd0);
        check("timeout_packets_cleared", 32'(packets_left), 32'd0);
        check("timeout_no_tx", 32'(tx_count - t0), 32'd0);
        d0 = done_count;
        send_header(16'd1);
        directed_packet(8'hBA, 0, 1'b0);
        check_done(d0);

        // Asynchronous reset in the middle of the data bytes.
        t0 = tx_count;
        send_header(16'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h40, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        exp_q.push_back({16'h4000, 8'h11});
        exp_q.push_back({16'h4001, 8'h22});
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_wr_en", 32'(wr_en), 32'd0);
        check("async_reset_busy", 32'(loader_busy), 32'd0);
        check("async_reset_packets_left", 32'(packets_left), 32'd0);
        check("async_reset_wr_addr", 32'(wr_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("reset_no_response", 32'(tx_count - t0), 32'd0);
        check("reset_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // Non-sync bytes in IDLE are ignored; sync bytes inside packets are data.
        stray = '{8'h00, 8'h55, 8'hAA, 8'h01};
        w0 = wr_count;
        for (int i = 0; i < 4; i++) send_byte(stray[i], 1'b0);
        @(negedge clk);
        check("stray_idle_busy", 32'(loader_busy), 32'd0);
        check("stray_no_writes", 32'(wr_count - w0), 32'd0);
        d0 = done_count;
        left = 1;
        send_header(16'd1);
        run_packet(16'($urandom), 7, 1'b0, 0, 1'b1, left);
        check_done(d0);
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
